mcycle_unit: RTL



---
 rtl/mcycle_pkg.sv | 30 +++
 rtl/mcycle_unit_if.sv | 34 +++
 rtl/mcycle_div_step.sv | 41 ++++
 rtl/mcycle_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mcycle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mcycle_pkg
// Description : Shared definitions for the iterative multiply/divide unit:
//               operation encodings, FSM state type and the iteration
//               counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mcycle_pkg;

    // MCycleOp encodings. Bit 1 selects divide, bit 0 selects unsigned.
    localparam logic [1:0] MC_SMUL = 2'b00;
    localparam logic [1:0] MC_UMUL = 2'b01;
    localparam logic [1:0] MC_SDIV = 2'b10;
    localparam logic [1:0] MC_UDIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } mc_state_t;

    // The counter must be able to hold WIDTH itself, since it increments
    // once more on the final iteration edge.
    function automatic int mc_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mcycle_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mcycle_unit_if
// Description : Request/response bundle between the decoder and the
//               multiply/divide unit.
//   Start, MCycleOp, Operand1, Operand2 : decoder -> unit
//   Result1, Result2, Busy, Done        : unit -> decoder
//   modport master : decoder side
//   modport slave  : unit side
// Revision    : 1.0 - initial release
// ============================================================================
interface mcycle_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             Start;
    logic [1:0]       MCycleOp;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic [WIDTH-1:0] Result1;
    logic [WIDTH-1:0] Result2;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, MCycleOp, Operand1, Operand2,
        input  Result1, Result2, Busy, Done
    );

    modport slave (
        input  Start, MCycleOp, Operand1, Operand2,
        output Result1, Result2, Busy, Done
    );
endinterface
`default_nettype wire

// File: rtl/mcycle_div_step.sv
`default_nettype none
// ============================================================================
// Module      : mcycle_div_step
// Description : One combinational restoring-division iteration on unsigned
//               magnitudes. Shifts the next dividend bit (MSB of the
//               quotient register) into the partial remainder, trial-
//               subtracts the divisor and shifts the quotient bit in.
//   i_rem     : partial remainder
//   i_quo     : quotient register (unconsumed dividend bits in the MSBs)
//   i_divisor : divisor magnitude
//   o_rem     : next partial remainder
//   o_quo     : next quotient register
// Revision    : 1.0 - initial release
// ============================================================================
module mcycle_div_step #(
    parameter int WIDTH = 32
) (
    input  wire [WIDTH-1:0] i_rem,
    input  wire [WIDTH-1:0] i_quo,
    input  wire [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    always_comb begin
        w_shift = {i_rem, i_quo[WIDTH-1]};
        w_diff  = w_shift - {1'b0, i_divisor};
        // The remainder is always below the divisor, so the trial difference
        // is negative exactly when its top bit is set.
        if (!w_diff[WIDTH]) begin
            o_rem = w_diff[WIDTH-1:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b1};
        end else begin
            o_rem = w_shift[WIDTH-1:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b0};
        end
    end
endmodule
`default_nettype wire

// File: rtl/mcycle_unit.sv
`default_nettype none
// ============================================================================
// Module      : mcycle_unit
// Description : Iterative signed/unsigned multiply and divide, one iteration
//               per clock. Busy is held while iterating; Done pulses for one
//               cycle when Result1/Result2 are valid.
//   CLK   : clock, rising edge
//   RESET : asynchronous, active-high
//   bus   : mcycle_unit_if.slave (Start, MCycleOp, Operand1, Operand2 in;
//           Result1, Result2, Busy, Done out)
// Build option : define MCYCLE_DIV_EN to build the divider. Without it,
//               divide ops complete in one cycle with zero results.
// Revision    : 1.0 - initial release
// ============================================================================
module mcycle_unit #(
    parameter int WIDTH = 32
) (
    input wire           CLK,
    input wire           RESET,
    mcycle_unit_if.slave bus
);
    import mcycle_pkg::*;

    localparam int                 c_CNT_W = mc_cnt_width(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    mc_state_t            r_state;
    mc_state_t            w_state_nxt;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_busy_nxt;
    logic                 w_done_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_neg1;
    logic                 r_neg2;
    logic [WIDTH-1:0]     r_addend;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   w_acc_nxt;
    logic [2*WIDTH-1:0]   w_mul_nxt;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH:0]       w_mul_sum;
    logic [WIDTH-1:0]     r_res1;
    logic [WIDTH-1:0]     r_res2;
    logic [WIDTH-1:0]     w_res1;
    logic [WIDTH-1:0]     w_res2;
    logic                 w_last;
    logic                 w_in_neg1;
    logic                 w_in_neg2;
    logic [WIDTH-1:0]     w_mag1;
    logic [WIDTH-1:0]     w_mag2;

    // Operand signs only matter for signed ops (op bit 0 clear).
    assign w_in_neg1 = ~bus.MCycleOp[0] & bus.Operand1[WIDTH-1];
    assign w_in_neg2 = ~bus.MCycleOp[0] & bus.Operand2[WIDTH-1];
    assign w_mag1    = w_in_neg1 ? -bus.Operand1 : bus.Operand1;
    assign w_mag2    = w_in_neg2 ? -bus.Operand2 : bus.Operand2;
    assign w_last    = (r_cnt == c_LAST);

    // Shift-add: the multiplier sits in the low half of the accumulator and
    // is consumed LSB first while the product grows in from the top.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + {1'b0, (r_acc[0] ? r_addend : {WIDTH{1'b0}})};
    assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

`ifdef MCYCLE_DIV_EN
    logic             r_is_div;
    logic             r_div0;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_div_quo;

    // Divide reuses the accumulator: remainder in the high half, quotient
    // (initially the dividend magnitude) in the low half.
    mcycle_div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .i_rem     (r_acc[2*WIDTH-1:WIDTH]),
        .i_quo     (r_acc[WIDTH-1:0]),
        .i_divisor (r_addend),
        .o_rem     (w_div_rem),
        .o_quo     (w_div_quo)
    );

    assign w_acc_nxt = r_is_div ? {w_div_rem, w_div_quo} : w_mul_nxt;
`else
    assign w_acc_nxt = w_mul_nxt;
`endif

    // Sign correction of the final iteration's value, written to the result
    // registers on the edge that enters DONE.
    always_comb begin
        w_prod = (r_neg1 ^ r_neg2) ? -w_acc_nxt : w_acc_nxt;
        w_res1 = w_prod[WIDTH-1:0];
        w_res2 = w_prod[2*WIDTH-1:WIDTH];
`ifdef MCYCLE_DIV_EN
        if (r_is_div) begin
            // With a zero divisor the restoring loop leaves the dividend
            // magnitude in the remainder, so restoring its sign yields
            // Operand1 unmodified.
            w_res2 = r_neg1 ? -w_acc_nxt[2*WIDTH-1:WIDTH]
                            : w_acc_nxt[2*WIDTH-1:WIDTH];
            if (r_div0) begin
                w_res1 = {WIDTH{1'b1}};
            end else begin
                w_res1 = (r_neg1 ^ r_neg2) ? -w_acc_nxt[WIDTH-1:0]
                                           : w_acc_nxt[WIDTH-1:0];
            end
        end
`endif
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.Start) begin
`ifdef MCYCLE_DIV_EN
                    w_state_nxt = ST_COMPUTE;
                    w_busy_nxt  = 1'b1;
`else
                    if (bus.MCycleOp[1]) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_COMPUTE;
                        w_busy_nxt  = 1'b1;
                    end
`endif
                end
            end
            ST_COMPUTE: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cnt    <= '0;
            r_neg1   <= 1'b0;
            r_neg2   <= 1'b0;
            r_addend <= '0;
            r_acc    <= '0;
            r_res1   <= '0;
            r_res2   <= '0;
`ifdef MCYCLE_DIV_EN
            r_is_div <= 1'b0;
            r_div0   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.Start) begin
                        r_cnt    <= '0;
                        r_neg1   <= w_in_neg1;
                        r_neg2   <= w_in_neg2;
                        // Multiply adds |Operand1| under control of |Operand2|;
                        // divide subtracts |Operand2| from |Operand1|.
                        r_addend <= bus.MCycleOp[1] ? w_mag2 : w_mag1;
                        r_acc    <= {{WIDTH{1'b0}},
                                     (bus.MCycleOp[1] ? w_mag1 : w_mag2)};
`ifdef MCYCLE_DIV_EN
                        r_is_div <= bus.MCycleOp[1];
                        r_div0   <= (bus.Operand2 == {WIDTH{1'b0}});
`else
                        if (bus.MCycleOp[1]) begin
                            r_res1 <= '0;
                            r_res2 <= '0;
                        end
`endif
                    end
                end
                ST_COMPUTE: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_res1 <= w_res1;
                        r_res2 <= w_res2;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.Result1 = r_res1;
    assign bus.Result2 = r_res2;
    assign bus.Busy    = r_busy;
    assign bus.Done    = r_done;

endmodule
`default_nettype wire
